// File: rtl/pe_group_sequencer_pkg.sv
// Shared lane/beat geometry and group FSM state for the PE group sequencer.
package pe_group_sequencer_pkg;
  localparam int LANES  = 16;
  localparam int LANE_W = 8;
  localparam int BEAT_W = LANES * LANE_W;
  localparam int DOT_W  = 32;

  typedef enum logic {IDLE, OPEN} grp_state_t;
endpackage

// File: rtl/pe_result_fifo.sv
// Sync result FIFO, non-fallthrough: a push is visible at the head one cycle later.
// Backpressure: push while full and pop while empty are ignored.
module pe_result_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end
endmodule

// File: rtl/pe_group_sequencer.sv
// Issues grouped beats to a fixed-latency PE and sums returned dots per group;
// last accept to out_valid is PE_LATENCY+2 cycles, and input credit keeps the result FIFO from overflowing.
module pe_group_sequencer
  import pe_group_sequencer_pkg::*;
#(
  parameter int PE_LATENCY = 2,
  parameter int OUT_DEPTH  = 4,
  parameter int MAX_BEATS  = 1024,
  parameter int ACC_W      = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [BEAT_W-1:0] in_feature,
  input  logic [BEAT_W-1:0] in_filter,
  output logic              pe_valid,
  output logic [BEAT_W-1:0] pe_feature,
  output logic [BEAT_W-1:0] pe_filter,
  input  logic [DOT_W-1:0]  pe_dot,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              busy,
  output logic              err_len
);
  localparam int CW = $clog2(OUT_DEPTH) + 1;
  localparam int BW = $clog2(MAX_BEATS) + 1;
  localparam logic [CW:0]   CREDIT_MAX = (CW+1)'(OUT_DEPTH);
  localparam logic [BW-1:0] CNT_LIMIT  = BW'(MAX_BEATS - 1);

  grp_state_t state, state_nxt;

  logic                  reset_hold;
  logic                  accept;
  logic                  last_accept;
  logic                  pe_last;
  logic [PE_LATENCY-1:0] sr_vld;
  logic [PE_LATENCY-1:0] sr_last;
  logic                  ret_vld;
  logic                  ret_last;
  logic [ACC_W-1:0]      acc;
  logic [ACC_W-1:0]      acc_sum;
  logic                  fifo_push;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CW-1:0]         pending;
  logic [BW-1:0]         beat_cnt;

  assign accept      = in_valid && in_ready;
  assign last_accept = accept && in_last;
  assign ret_vld     = sr_vld[PE_LATENCY-1];
  assign ret_last    = sr_last[PE_LATENCY-1];
  assign acc_sum     = acc + ACC_W'($signed(pe_dot));
  assign fifo_push   = ret_vld && ret_last;

  // Credit counts every closed group not yet popped, so it covers results still inside the PE.
  assign in_ready  = !reset_hold && !fifo_full &&
                     (({1'b0, fifo_count} + {1'b0, pending}) < CREDIT_MAX);
  assign out_valid = !fifo_empty;
  assign busy      = (state == OPEN) || (beat_cnt != '0) || pe_valid || (|sr_vld) || (pending != '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) reset_hold <= 1'b1;
    else       reset_hold <= 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pe_valid   <= 1'b0;
      pe_last    <= 1'b0;
      pe_feature <= '0;
      pe_filter  <= '0;
      sr_vld     <= '0;
      sr_last    <= '0;
    end else begin
      pe_valid <= accept;
      pe_last  <= last_accept;
      if (accept) begin
        pe_feature <= in_feature;
        pe_filter  <= in_filter;
      end
      sr_vld[0]  <= pe_valid;
      sr_last[0] <= pe_last;
      for (int i = 1; i < PE_LATENCY; i++) begin
        sr_vld[i]  <= sr_vld[i-1];
        sr_last[i] <= sr_last[i-1];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc      <= '0;
      pending  <= '0;
      beat_cnt <= '0;
      err_len  <= 1'b0;
    end else begin
      if (ret_vld) acc <= ret_last ? '0 : acc_sum;
      if (last_accept && !fifo_push)      pending <= pending + CW'(1);
      else if (fifo_push && !last_accept) pending <= pending - CW'(1);
      // An overlong group keeps flowing; the counter simply parks at its limit.
      if (accept) begin
        if (in_last)                     beat_cnt <= '0;
        else if (beat_cnt == CNT_LIMIT)  err_len  <= 1'b1;
        else                             beat_cnt <= beat_cnt + BW'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !in_last) state_nxt = OPEN;
      OPEN:    if (last_accept)        state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  pe_result_fifo #(
    .DEPTH (OUT_DEPTH),
    .W     (ACC_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (acc_sum),
    .pop       (out_ready),
    .pop_data  (out_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );
endmodule
